// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32I pipeline types, opcodes and immediate helpers
package rv_pkg;

  // Canonical bubble: addi x0, x0, 0
  localparam logic [31:0] NOP_ENC    = 32'h0000_0013;

  // Major opcodes used by fetch-side control-flow handling
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;

  // Contents of the IF/ID pipeline register
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        valid;
    logic        pred_taken;
  } ifid_t;

  // Sign-extended B-type immediate (bit 0 is always zero)
  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  // Bubble value placed in a stage register when it holds no instruction
  function automatic ifid_t ifid_bubble(input logic [31:0] nop);
    ifid_t b;
    b.pc         = 32'h0000_0000;
    b.pc_plus4   = 32'h0000_0004;
    b.instr      = nop;
    b.valid      = 1'b0;
    b.pred_taken = 1'b0;
    ifid_bubble  = b;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with hold and flush controls
module if_id_reg
  import rv_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = rv_pkg::NOP_ENC
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  hold,
  input  logic  flush,
  input  ifid_t d,
  output ifid_t q
);

  // Flush beats hold so a redirect during a stall still drops the wrong-path slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= ifid_bubble(NOP_INSTR);
    end else if (flush) begin
      q <= ifid_bubble(NOP_INSTR);
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - RV32I fetch stage: PC, imem address, IF/ID capture (optional FETCH_BTFN_PREDICT_EN)
module if_stage
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = rv_pkg::NOP_ENC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        ifid_pred_taken
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        pred_taken;
  ifid_t       ifid_d;
  ifid_t       ifid_q;

  // Sequential fetch address; wraps naturally at 2^32
  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

`ifdef FETCH_BTFN_PREDICT_EN
  logic [31:0] pred_target;

  // Backward conditional branches (negative offset) are assumed to be loop edges
  assign pred_taken  = (imem_rdata[6:0] == OPC_BRANCH) && imem_rdata[31];
  assign pred_target = pc + imm_b(imem_rdata);
  // Low bits dropped so a half-word target cannot misalign the fetch PC
  assign next_pc     = pred_taken ? {pred_target[31:2], 2'b00} : pc_plus4;
`else
  assign pred_taken  = 1'b0;
  assign next_pc     = pc_plus4;
`endif

  // Program counter: redirect wins over stall, stall freezes fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= {RESET_PC[31:2], 2'b00};
    end else if (redirect_valid) begin
      pc <= {redirect_pc[31:2], 2'b00};
    end else if (!stall) begin
      pc <= next_pc;
    end
  end

  assign ifid_d = '{pc, pc_plus4, imem_rdata, 1'b1, pred_taken};

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk   (clk),
    .rst   (rst),
    .hold  (stall),
    .flush (redirect_valid),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign ifid_pc         = ifid_q.pc;
  assign ifid_pc_plus4   = ifid_q.pc_plus4;
  assign ifid_instr      = ifid_q.instr;
  assign ifid_valid      = ifid_q.valid;
  assign ifid_pred_taken = ifid_q.pred_taken;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        ifid_pred_taken;

  int n_checks;
  int n_fail;

  if_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .ifid_pc         (ifid_pc),
    .ifid_pc_plus4   (ifid_pc_plus4),
    .ifid_instr      (ifid_instr),
    .ifid_valid      (ifid_valid),
    .ifid_pred_taken (ifid_pred_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction memory holding the test program
  always_comb begin
    case (imem_addr)
      32'h0000_0000: imem_rdata = 32'h0050_0093;
      32'h0000_0004: imem_rdata = 32'h00A0_0113;
      32'h0000_0008: imem_rdata = 32'h0020_81B3;
      32'h0000_0020: imem_rdata = 32'h0073_8463;
      32'h0000_0040: imem_rdata = 32'hFE00_0EE3;
      default:       imem_rdata = 32'h0000_0013;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_addr",   imem_addr,       32'h0);
    check("rst_pc",     ifid_pc,         32'h0);
    check("rst_pc4",    ifid_pc_plus4,   32'h4);
    check("rst_instr",  ifid_instr,      32'h13);
    check("rst_valid",  {31'b0, ifid_valid},      32'h0);
    check("rst_pred",   {31'b0, ifid_pred_taken}, 32'h0);
    rst = 1'b0;

    step();
    check("c1_pc",    ifid_pc,    32'h0);
    check("c1_instr", ifid_instr, 32'h0050_0093);
    check("c1_valid", {31'b0, ifid_valid}, 32'h1);
    check("c1_addr",  imem_addr,  32'h4);
    step();
    check("c2_pc",    ifid_pc,       32'h4);
    check("c2_instr", ifid_instr,    32'h00A0_0113);
    check("c2_pc4",   ifid_pc_plus4, 32'h8);
    step();
    check("c3_pc",    ifid_pc,    32'h8);
    check("c3_instr", ifid_instr, 32'h0020_81B3);

    stall = 1'b1;
    step();
    step();
    check("stall_addr",  imem_addr,  32'hC);
    check("stall_pc",    ifid_pc,    32'h8);
    check("stall_instr", ifid_instr, 32'h0020_81B3);
    check("stall_valid", {31'b0, ifid_valid}, 32'h1);
    stall = 1'b0;
    step();
    check("unstall_pc",   ifid_pc,   32'hC);
    check("unstall_addr", imem_addr, 32'h10);

    repeat (4) step();
    check("fwd_addr0", imem_addr, 32'h20);
    step();
    check("fwd_addr1",  imem_addr,  32'h24);
    check("fwd_instr",  ifid_instr, 32'h0073_8463);
    check("fwd_pred",   {31'b0, ifid_pred_taken}, 32'h0);

    redirect_valid = 1'b1;
    redirect_pc    = 32'h28;
    step();
    redirect_valid = 1'b0;
    check("redir_valid", {31'b0, ifid_valid}, 32'h0);
    check("redir_instr", ifid_instr,    32'h13);
    check("redir_pc",    ifid_pc,       32'h0);
    check("redir_pc4",   ifid_pc_plus4, 32'h4);
    check("redir_addr",  imem_addr,     32'h28);
    step();
    check("tgt_pc",    ifid_pc,    32'h28);
    check("tgt_instr", ifid_instr, 32'h13);
    check("tgt_valid", {31'b0, ifid_valid}, 32'h1);

    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2B;
    step();
    redirect_valid = 1'b0;
    check("rs_addr",  imem_addr, 32'h28);
    check("rs_valid", {31'b0, ifid_valid}, 32'h0);
    step();
    check("rs_hold_addr",  imem_addr, 32'h28);
    check("rs_hold_valid", {31'b0, ifid_valid}, 32'h0);
    stall = 1'b0;

    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_pc    = 32'h200;
    step();
    redirect_valid = 1'b0;
    check("rr_addr",  imem_addr, 32'h200);
    check("rr_valid", {31'b0, ifid_valid}, 32'h0);
    check("rr_instr", ifid_instr, 32'h13);

    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_addr1", imem_addr,     32'h0);
    check("wrap_pc",    ifid_pc,       32'hFFFF_FFFC);
    check("wrap_pc4",   ifid_pc_plus4, 32'h0);
    check("wrap_valid", {31'b0, ifid_valid}, 32'h1);

    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    check("bwd_addr0", imem_addr, 32'h40);
    step();
    check("bwd_instr", ifid_instr, 32'hFE00_0EE3);
`ifdef FETCH_BTFN_PREDICT_EN
    check("bwd_addr1", imem_addr, 32'h3C);
    check("bwd_pred",  {31'b0, ifid_pred_taken}, 32'h1);
`else
    check("bwd_addr1", imem_addr, 32'h44);
    check("bwd_pred",  {31'b0, ifid_pred_taken}, 32'h0);
`endif

    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_pc    = 32'h80;
    step();
    redirect_valid = 1'b0;
    check("ovr_addr", imem_addr, 32'h80);
    check("ovr_pred", {31'b0, ifid_pred_taken}, 32'h0);

    step();
    step();
    check("pre_rst_valid", {31'b0, ifid_valid}, 32'h1);
    rst = 1'b1;
    #1;
    check("arst_addr",  imem_addr,  32'h0);
    check("arst_valid", {31'b0, ifid_valid}, 32'h0);
    check("arst_instr", ifid_instr, 32'h13);
    step();
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline.
- Owns the program counter and drives the word address into the combinational instruction memory.
- Captures the returned instruction into the IF/ID pipeline register for the decode stage.
- Honours stall from hazard detection and PC redirect (taken branch/jump resolved in EX); inserts bubbles on redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID when invalid.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hold PC and IF/ID (load-use hazard from ID).
- redirect_valid  input  1  EX resolved a control transfer that differs from the fetched path.
- redirect_pc  input  32  target PC for redirect.
- imem_addr  output  32  byte address to instruction memory (combinational = pc).
- imem_rdata  input  32  instruction word returned combinationally for imem_addr.
- ifid_pc  output  32  PC of instruction held in IF/ID.
- ifid_pc_plus4  output  32  ifid_pc + 4, for JAL/JALR link.
- ifid_instr  output  32  instruction held in IF/ID.
- ifid_valid  output  1  IF/ID holds a real instruction.
- ifid_pred_taken  output  1  fetch predicted this instruction taken (0 when feature absent).

Behaviour:
- Reset (async assert, sync-safe release): pc=RESET_PC; ifid_pc=0; ifid_pc_plus4=4; ifid_instr=NOP_INSTR; ifid_valid=0; ifid_pred_taken=0. First valid instruction appears in IF/ID one cycle after rst deasserts.
- imem_addr = pc every cycle; memory latency zero (read same cycle).
- Priority per rising edge: rst > redirect_valid > stall > normal.
- Normal: pc <= next_pc; IF/ID <= {pc, pc+4, imem_rdata, valid=1, pred}.
- Stall: pc and all IF/ID fields hold exactly.
- Redirect (including when stall=1): pc <= {redirect_pc[31:2],2'b00}; IF/ID <= bubble (NOP_INSTR, valid=0, pred=0, pc fields 0/4). Exactly one bubble inserted by this stage per redirect.
- Consecutive redirects: each one reloads pc; the last wins; IF/ID stays bubble.
- next_pc = pc+4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0) unless prediction fires.
- PC low two bits always 00; no misalignment exception generated here.
- Latency: PC to IF/ID = 1 cycle; redirect to first target-path valid instruction in IF/ID = 2 edges.

Optional Feature:
- Macro FETCH_BTFN_PREDICT_EN.
- Defined: static backward-taken/forward-not-taken prediction. When imem_rdata[6:0]==7'b1100011 (branch) and imem_rdata[31]==1 (negative B-immediate), next_pc = pc + sign-extended imm_b, and the captured ifid_pred_taken=1. EX must compare against the prediction and redirect to pc+4 on mispredict. Stall and redirect rules are unchanged; redirect overrides prediction.
- Not defined: no decode in fetch; next_pc always pc+4; ifid_pred_taken tied 0.

Decomposition:
- Shared package rv_pkg: NOP_INSTR value, OPC_BRANCH/OPC_JAL/OPC_JALR opcode constants, B-immediate extraction function, IF/ID struct typedef (pc, pc_plus4, instr, valid, pred_taken).
- Sub-module if_id_reg: the IF/ID pipeline register with hold/flush controls, reused in shape by later stage registers. PC logic stays in if_stage.

Test Plan:
- Reset release with the standard program (0x00500093 at 0) -> cycle 1: ifid_pc=0, ifid_instr=0x00500093, ifid_valid=1; cycle 2: ifid_pc=4, instr=0x00A00113.
- stall=1 for 2 cycles while IF/ID holds pc=8 (0x002081B3) -> imem_addr stays 0xC, IF/ID unchanged; on release ifid_pc=0xC.
- redirect_valid=1, redirect_pc=0x28 while pc=0x24 -> next edge ifid_valid=0, ifid_instr=0x00000013; following edge ifid_pc=0x28, ifid_instr=0x00000013 (nop), valid=1.
- redirect_valid=1 with stall=1 simultaneously, redirect_pc=0x2B -> pc becomes 0x28 (low bits cleared), IF/ID bubbled.
- pc forced via redirect to 0xFFFFFFFC -> next pc/imem_addr=0x00000000; ifid_pc_plus4=0x00000000.
- With FETCH_BTFN_PREDICT_EN, bench memory returns 0xFE000EE3 (beq x0,x0,-4) at 0x40 -> next imem_addr=0x3C, ifid_pred_taken=1; forward beq 0x00738463 at 0x20 -> next imem_addr=0x24, pred=0. Without macro: 0xFE000EE3 at 0x40 -> next addr 0x44, pred=0.
